// File: rtl/trena_pkg.sv
// trena_pkg: shared constants for the tape-measure serial transmitter.
//   - FSM state encodings (also the db_estado debug codes)
//   - ASCII base for digits, message terminator, default bit period
//   - frame length and helpers that build a 7O1 frame
package trena_pkg;

    localparam logic [2:0] OCIOSO          = 3'b000;
    localparam logic [2:0] CARREGA         = 3'b001;
    localparam logic [2:0] TRANSMITE       = 3'b010;
    localparam logic [2:0] FIM_CARACTERE   = 3'b011;
    localparam logic [2:0] ESTADO_INVALIDO = 3'b111;

    localparam logic [6:0] ASCII_BASE = 7'h30;
    localparam logic [6:0] TERMINADOR = 7'h23;

    // 115200 baud at 50 MHz
    localparam int CLKS_POR_BIT_PADRAO = 434;
    localparam int FRAME_LEN           = 10;

    // Nibbles A-F are not trapped: they simply land on 0x3A..0x3F.
    function automatic logic [6:0] ascii_de(input logic [3:0] nibble);
        return ASCII_BASE + {3'b000, nibble};
    endfunction

    // Bit 0 goes out first: start, 7 data bits LSB first, odd parity, stop.
    function automatic logic [FRAME_LEN-1:0] monta_quadro(input logic [6:0] c);
        return {1'b1, ~^c, c, 1'b0};
    endfunction

endpackage

// File: rtl/contador_m.sv
// contador_m: modulo-M counter used as the per-bit timer.
//   clock  in  system clock
//   reset  in  async active-low reset
//   zera   in  synchronous clear (wins over conta)
//   conta  in  count enable
//   fim    out high while the count sits at M-1 (end of count)
module contador_m #(
    parameter int M = 4,
    parameter int N = $clog2(M)
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    logic [N-1:0] q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            q <= '0;
        else if (zera)
            q <= '0;
        else if (conta)
            q <= (q == N'(M-1)) ? '0 : q + N'(1);
    end

    assign fim = (q == N'(M-1));

endmodule

// File: rtl/trena_transmissor.sv
// trena_transmissor: sends a 3-digit BCD measurement as "ddd#" over a
// 7O1 asynchronous serial line.
//   clock         in   system clock
//   reset         in   async active-low reset
//   envia         in   level request, sampled only while idle
//   medida[11:0]  in   {centena, dezena, unidade}, latched on acceptance
//   saida_serial  out  registered serial line, idle high
//   ocupado       out  high whenever not idle
//   fim_digito    out  one-cycle pulse after each character
//   fim_envio     out  one-cycle pulse with the last fim_digito
//   db_estado     out  state code (111 for an illegal state)
module trena_transmissor
    import trena_pkg::*;
#(
    parameter int CLKS_POR_BIT = CLKS_POR_BIT_PADRAO
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        envia,
    input  logic [11:0] medida,
    output logic        saida_serial,
    output logic        ocupado,
    output logic        fim_digito,
    output logic        fim_envio,
    output logic [2:0]  db_estado
);

    logic [2:0]           estado;
    logic [11:0]          medida_reg;
    logic [1:0]           indice;
    logic [3:0]           bit_idx;
    logic [FRAME_LEN-1:0] quadro;
    logic [FRAME_LEN-1:0] quadro_novo;
    logic [6:0]           caractere;
    logic                 transmitindo;
    logic                 fim_tempo;
    logic                 tick;

    assign transmitindo = (estado == TRANSMITE);

    // Held clear outside TRANSMITE so every bit starts with a full period.
    contador_m #(.M(CLKS_POR_BIT)) u_tempo_bit (
        .clock (clock),
        .reset (reset),
        .zera  (!transmitindo),
        .conta (transmitindo),
        .fim   (fim_tempo)
    );

    assign tick = transmitindo & fim_tempo;

    always_comb begin
        caractere = TERMINADOR;
        case (indice)
            2'd0:    caractere = ascii_de(medida_reg[11:8]);
            2'd1:    caractere = ascii_de(medida_reg[7:4]);
            2'd2:    caractere = ascii_de(medida_reg[3:0]);
            default: caractere = TERMINADOR;
        endcase
    end

    assign quadro_novo = monta_quadro(caractere);

    // saida_serial is computed one cycle ahead so the flop presents the
    // right bit on the first TRANSMITE cycle and returns high with FIM.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado       <= OCIOSO;
            medida_reg   <= '0;
            indice       <= '0;
            bit_idx      <= '0;
            quadro       <= '1;
            saida_serial <= 1'b1;
        end else begin
            case (estado)
                OCIOSO: begin
                    saida_serial <= 1'b1;
                    if (envia) begin
                        medida_reg <= medida;
                        indice     <= '0;
                        estado     <= CARREGA;
                    end
                end
                CARREGA: begin
                    quadro       <= quadro_novo;
                    bit_idx      <= '0;
                    saida_serial <= quadro_novo[0];
                    estado       <= TRANSMITE;
                end
                TRANSMITE: begin
                    if (tick) begin
                        if (bit_idx == 4'(FRAME_LEN-1)) begin
                            saida_serial <= 1'b1;
                            estado       <= FIM_CARACTERE;
                        end else begin
                            quadro       <= {1'b1, quadro[FRAME_LEN-1:1]};
                            saida_serial <= quadro[1];
                            bit_idx      <= bit_idx + 4'd1;
                        end
                    end
                end
                FIM_CARACTERE: begin
                    saida_serial <= 1'b1;
                    if (indice == 2'd3) begin
                        estado <= OCIOSO;
                    end else begin
                        indice <= indice + 2'd1;
                        estado <= CARREGA;
                    end
                end
                default: begin
                    saida_serial <= 1'b1;
                    estado       <= OCIOSO;
                end
            endcase
        end
    end

    assign ocupado    = (estado != OCIOSO);
    assign fim_digito = (estado == FIM_CARACTERE);
    assign fim_envio  = (estado == FIM_CARACTERE) && (indice == 2'd3);

    always_comb begin
        case (estado)
            OCIOSO, CARREGA, TRANSMITE, FIM_CARACTERE: db_estado = estado;
            default:                                   db_estado = ESTADO_INVALIDO;
        endcase
    end

endmodule

// File: tb/tb_trena_transmissor.sv
// tb_trena_transmissor: directed bench for trena_transmissor at 4 clocks/bit.
module tb_trena_transmissor;

    localparam int C = 4;

    // Hand-computed frames {stop, odd parity, ascii, start}
    localparam logic [9:0] F0 = {1'b1, 1'b1, 7'h30, 1'b0};
    localparam logic [9:0] F1 = {1'b1, 1'b0, 7'h31, 1'b0};
    localparam logic [9:0] F2 = {1'b1, 1'b0, 7'h32, 1'b0};
    localparam logic [9:0] F3 = {1'b1, 1'b1, 7'h33, 1'b0};
    localparam logic [9:0] F4 = {1'b1, 1'b0, 7'h34, 1'b0};
    localparam logic [9:0] F5 = {1'b1, 1'b1, 7'h35, 1'b0};
    localparam logic [9:0] FA = {1'b1, 1'b1, 7'h3A, 1'b0};
    localparam logic [9:0] FF = {1'b1, 1'b1, 7'h3F, 1'b0};
    localparam logic [9:0] FH = {1'b1, 1'b0, 7'h23, 1'b0};

    logic        clock;
    logic        reset;
    logic        envia;
    logic [11:0] medida;
    logic        saida_serial;
    logic        ocupado;
    logic        fim_digito;
    logic        fim_envio;
    logic [2:0]  db_estado;

    int checks   = 0;
    int failures = 0;

    trena_transmissor #(.CLKS_POR_BIT(C)) dut (
        .clock        (clock),
        .reset        (reset),
        .envia        (envia),
        .medida       (medida),
        .saida_serial (saida_serial),
        .ocupado      (ocupado),
        .fim_digito   (fim_digito),
        .fim_envio    (fim_envio),
        .db_estado    (db_estado)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Entered one sample after the CARREGA edge of the first character;
    // returns at the FIM_CARACTERE sample of the last character.
    task automatic run_msg(input logic [9:0] f0, input logic [9:0] f1,
                           input logic [9:0] f2, input logic [9:0] f3,
                           input bit disturb);
        logic [9:0] f;
        for (int c = 0; c < 4; c++) begin
            f = (c == 0) ? f0 : (c == 1) ? f1 : (c == 2) ? f2 : f3;
            chk($sformatf("carrega_estado_c%0d", c), 12'(db_estado), 12'h001);
            chk($sformatf("carrega_linha_c%0d", c), 12'(saida_serial), 12'h001);
            chk($sformatf("carrega_ocupado_c%0d", c), 12'(ocupado), 12'h001);
            for (int b = 0; b < 10; b++) begin
                for (int k = 0; k < C; k++) begin
                    step();
                    if (disturb && c == 1 && b == 2 && k == 0) begin
                        medida = 12'h999;
                        envia  = 1'b1;
                    end
                    if (disturb && c == 1 && b == 2 && k == 1)
                        envia = 1'b0;
                    chk($sformatf("linha_c%0d_b%0d_k%0d", c, b, k), 12'(saida_serial), 12'(f[b]));
                    chk("ocupado_tx", 12'(ocupado), 12'h001);
                    chk("fim_digito_tx", 12'(fim_digito), 12'h000);
                    chk("fim_envio_tx", 12'(fim_envio), 12'h000);
                end
            end
            step();
            chk($sformatf("fim_digito_c%0d", c), 12'(fim_digito), 12'h001);
            chk($sformatf("fim_envio_c%0d", c), 12'(fim_envio), (c == 3) ? 12'h001 : 12'h000);
            chk($sformatf("fim_estado_c%0d", c), 12'(db_estado), 12'h003);
            chk($sformatf("fim_linha_c%0d", c), 12'(saida_serial), 12'h001);
            if (c < 3) step();
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_estado"}, 12'(db_estado), 12'h000);
        chk({tag, "_ocupado"}, 12'(ocupado), 12'h000);
        chk({tag, "_linha"}, 12'(saida_serial), 12'h001);
        chk({tag, "_fim_digito"}, 12'(fim_digito), 12'h000);
        chk({tag, "_fim_envio"}, 12'(fim_envio), 12'h000);
    endtask

    initial begin
        reset  = 1'b1;
        envia  = 1'b0;
        medida = 12'h000;
        #3 reset = 1'b0;
        #1 check_idle("reset");
        step();
        step();
        reset = 1'b0;
        step();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle("idle_pos_reset");
        end

        // "123#" with a mid-message envia pulse and medida change
        envia  = 1'b1;
        medida = 12'h123;
        step();
        envia = 1'b0;
        run_msg(F1, F2, F3, FH, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            check_idle("pos_123");
        end

        // Non-BCD digits
        envia  = 1'b1;
        medida = 12'hA0F;
        step();
        envia = 1'b0;
        run_msg(FA, F0, FF, FH, 1'b0);
        step();
        check_idle("pos_A0F");

        // Reset in the middle of the second character
        envia  = 1'b1;
        medida = 12'h123;
        step();
        envia = 1'b0;
        chk("abort_carrega0", 12'(db_estado), 12'h001);
        repeat (42) step();
        chk("abort_carrega1", 12'(db_estado), 12'h001);
        repeat (18) step();
        chk("abort_bit4", 12'(saida_serial), 12'h000);
        #2 reset = 1'b0;
        #1 check_idle("abort_reset");
        step();
        reset = 1'b1;
        step();
        check_idle("abort_release");
        envia  = 1'b1;
        medida = 12'h045;
        step();
        envia = 1'b0;
        run_msg(F0, F4, F5, FH, 1'b0);
        step();
        check_idle("pos_045");

        // envia held high: back-to-back with one idle cycle between
        envia  = 1'b1;
        medida = 12'h123;
        step();
        run_msg(F1, F2, F3, FH, 1'b0);
        step();
        chk("b2b_gap_estado", 12'(db_estado), 12'h000);
        chk("b2b_gap_ocupado", 12'(ocupado), 12'h000);
        medida = 12'h045;
        step();
        envia = 1'b0;
        run_msg(F0, F4, F5, FH, 1'b0);
        step();
        check_idle("b2b_fim");
        step();
        check_idle("b2b_fim2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a stalled run
    initial begin
        #200000;
        failures++;
        $display("FAIL timeout observed=running expected=finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
